// File: rtl/rpn_operand_stack_pkg.sv
// Shared definitions for the RPN operand stack: command codes, cell select and stack actions.
// The ALU control FSM imports the same command codes.
package rpn_operand_stack_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP    = 3'b000,
        OP_PUSH   = 3'b001,
        OP_POP    = 3'b010,
        OP_SWAP   = 3'b011,
        OP_DUP    = 3'b100,
        OP_REDUCE = 3'b101,
        OP_CLEAR  = 3'b110
    } op_e;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_ABOVE,
        SEL_BELOW,
        SEL_LOAD
    } cell_sel_e;

    // Legal, decoded stack action for one edge; illegal commands decode to ACT_HOLD.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_PUSH,
        ACT_POP,
        ACT_SWAP,
        ACT_DUP,
        ACT_REDUCE,
        ACT_CLEAR
    } act_e;

endpackage

// File: rtl/rpn_operand_stack_if.sv
// Command/observation bundle between the ALU datapath (master) and the operand stack (slave).
interface rpn_operand_stack_if
    import rpn_operand_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             ENABLE;
    logic [OP_W-1:0]  OP;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] TOP;
    logic [WIDTH-1:0] NEXT;
    logic [CNT_W-1:0] COUNT;
    logic             EMPTY;
    logic             FULL;
    logic             OVF;
    logic             UNF;

    modport master (
        output ENABLE, OP, D,
        input  TOP, NEXT, COUNT, EMPTY, FULL, OVF, UNF
    );

    modport slave (
        input  ENABLE, OP, D,
        output TOP, NEXT, COUNT, EMPTY, FULL, OVF, UNF
    );

endinterface

// File: rtl/rpn_operand_stack_stack_cell.sv
// One stack entry: WIDTH-bit register with synchronous reset and a
// hold / from-above / from-below / load next-value select.
module stack_cell
    import rpn_operand_stack_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  cell_sel_e        sel,
    input  logic [WIDTH-1:0] from_above,
    input  logic [WIDTH-1:0] from_below,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (sel)
                SEL_ABOVE: q <= from_above;
                SEL_BELOW: q <= from_below;
                SEL_LOAD:  q <= load_val;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/rpn_operand_stack.sv
// LIFO operand stack for the RPN ALU: shift-style storage, one command per enabled edge,
// sticky overflow/underflow flags instead of state corruption.
module rpn_operand_stack
    import rpn_operand_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic               CLOCK,
    input logic               RESET,
    rpn_operand_stack_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    logic [WIDTH-1:0] entry    [DEPTH];
    logic [WIDTH-1:0] load_val [DEPTH];
    cell_sel_e        sel      [DEPTH];

    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             unf_q;
    logic             is_empty;
    logic             is_full;
    logic             ovf_set;
    logic             unf_set;
    act_e             act;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    // Command legality: an illegal command only raises a flag, the stack holds.
    always_comb begin
        act     = ACT_HOLD;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.ENABLE) begin
            case (bus.OP)
                OP_PUSH: begin
                    if (!is_full) act = ACT_PUSH;
                    else          ovf_set = 1'b1;
                end
                OP_POP: begin
                    if (!is_empty) act = ACT_POP;
                    else           unf_set = 1'b1;
                end
                OP_SWAP: begin
                    if (count_q >= TWO_C) act = ACT_SWAP;
                    else                  unf_set = 1'b1;
                end
                OP_DUP: begin
                    if (is_empty)     unf_set = 1'b1;
                    else if (is_full) ovf_set = 1'b1;
                    else              act = ACT_DUP;
                end
                OP_REDUCE: begin
                    if (count_q >= TWO_C) act = ACT_REDUCE;
                    else                  unf_set = 1'b1;
                end
                OP_CLEAR: act = ACT_CLEAR;
                default:  act = ACT_HOLD;
            endcase
        end
    end

    // Per-cell select; the bottom cell's from_below is tied to zero so pops vacate with 0.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel[i]      = SEL_HOLD;
            load_val[i] = '0;
            case (act)
                ACT_PUSH: begin
                    if (i == 0) begin
                        sel[i]      = SEL_LOAD;
                        load_val[i] = bus.D;
                    end else begin
                        sel[i] = SEL_ABOVE;
                    end
                end
                ACT_POP: sel[i] = SEL_BELOW;
                ACT_SWAP: begin
                    if (i == 0) begin
                        sel[i]      = SEL_LOAD;
                        load_val[i] = entry[1];
                    end else if (i == 1) begin
                        sel[i]      = SEL_LOAD;
                        load_val[i] = entry[0];
                    end
                end
                ACT_DUP: begin
                    if (i != 0) sel[i] = SEL_ABOVE;
                end
                ACT_REDUCE: begin
                    if (i == 0) begin
                        sel[i]      = SEL_LOAD;
                        load_val[i] = bus.D;
                    end else begin
                        sel[i] = SEL_BELOW;
                    end
                end
                ACT_CLEAR: sel[i] = SEL_LOAD;
                default:   sel[i] = SEL_HOLD;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        logic [WIDTH-1:0] above;
        logic [WIDTH-1:0] below;

        if (g == 0) begin : g_top
            assign above = '0;
        end else begin : g_mid
            assign above = entry[g-1];
        end

        if (g == DEPTH - 1) begin : g_bottom
            assign below = '0;
        end else begin : g_upper
            assign below = entry[g+1];
        end

        stack_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk       (CLOCK),
            .rst       (RESET),
            .sel       (sel[g]),
            .from_above(above),
            .from_below(below),
            .load_val  (load_val[g]),
            .q         (entry[g])
        );
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (act)
                ACT_PUSH, ACT_DUP:  count_q <= count_q + ONE_C;
                ACT_POP, ACT_REDUCE: count_q <= count_q - ONE_C;
                ACT_CLEAR:          count_q <= '0;
                default:            count_q <= count_q;
            endcase
            if (act == ACT_CLEAR) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (ovf_set) ovf_q <= 1'b1;
                if (unf_set) unf_q <= 1'b1;
            end
        end
    end

    assign bus.TOP   = entry[0];
    assign bus.NEXT  = entry[1];
    assign bus.COUNT = count_q;
    assign bus.EMPTY = is_empty;
    assign bus.FULL  = is_full;
    assign bus.OVF   = ovf_q;
    assign bus.UNF   = unf_q;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Scoreboard bench for rpn_operand_stack: directed scenarios then random commands,
// checked against a queue-based LIFO model.
module tb_rpn_operand_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        int top;
        int next;
        int count;
        int empty;
        int full;
        int ovf;
        int unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model state: stk[0] is the top of stack.
    int stk[$];
    int m_ovf = 0;
    int m_unf = 0;

    rpn_operand_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rpn_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_field(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_apply(input bit r, input bit en, input int op, input int d);
        int t;
        if (r) begin
            stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (en) begin
            case (op)
                1: if (stk.size() < DEPTH) stk.push_front(d); else m_ovf = 1;
                2: if (stk.size() >= 1) void'(stk.pop_front()); else m_unf = 1;
                3: if (stk.size() >= 2) begin
                       t = stk[0]; stk[0] = stk[1]; stk[1] = t;
                   end else m_unf = 1;
                4: if (stk.size() == 0) m_unf = 1;
                   else if (stk.size() == DEPTH) m_ovf = 1;
                   else stk.push_front(stk[0]);
                5: if (stk.size() >= 2) begin
                       void'(stk.pop_front());
                       void'(stk.pop_front());
                       stk.push_front(d);
                   end else m_unf = 1;
                6: begin
                       stk.delete();
                       m_ovf = 0;
                       m_unf = 0;
                   end
                default: ;
            endcase
        end
    endfunction

    task automatic step(input bit r, input bit en, input int op, input int d);
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus.ENABLE = en;
        bus.OP     = 3'(op);
        bus.D      = 8'(d);
        model_apply(r, en, op, d);
        e.top   = (stk.size() > 0) ? stk[0] : 0;
        e.next  = (stk.size() > 1) ? stk[1] : 0;
        e.count = stk.size();
        e.empty = (stk.size() == 0) ? 1 : 0;
        e.full  = (stk.size() == DEPTH) ? 1 : 0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
    endtask

    // Monitor: the stack presents fresh state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_field("TOP",   int'(bus.TOP),   e.top);
                check_field("NEXT",  int'(bus.NEXT),  e.next);
                check_field("COUNT", int'(bus.COUNT), e.count);
                check_field("EMPTY", int'(bus.EMPTY), e.empty);
                check_field("FULL",  int'(bus.FULL),  e.full);
                check_field("OVF",   int'(bus.OVF),   e.ovf);
                check_field("UNF",   int'(bus.UNF),   e.unf);
            end
        end
    end

    initial begin
        bus.ENABLE = 1'b0;
        bus.OP     = '0;
        bus.D      = '0;

        // Reset, fill, overflow
        step(1, 0, 0, 0);
        step(0, 1, 1, 'h11);
        step(0, 1, 1, 'h22);
        step(0, 1, 1, 'h33);
        step(0, 1, 1, 'h44);
        step(0, 1, 1, 'h55);
        // Swap and reduce
        step(0, 1, 3, 0);
        step(0, 1, 5, 'h77);
        // Drain, underflow, clear
        step(0, 1, 2, 0);
        step(0, 1, 2, 0);
        step(0, 1, 2, 0);
        step(0, 1, 2, 0);
        step(0, 1, 6, 0);
        // Dup, then swap with one entry
        step(0, 1, 1, 'h05);
        step(0, 1, 4, 0);
        step(0, 1, 2, 0);
        step(0, 1, 3, 0);
        // Disabled push, reserved opcode
        for (int i = 0; i < 3; i++) step(0, 0, 1, 'hAA);
        step(0, 1, 7, 'hBB);
        step(0, 1, 4, 0);
        step(0, 1, 4, 0);
        step(0, 1, 4, 0);
        step(0, 1, 4, 0);
        // Reset wins over push
        step(0, 1, 6, 0);
        step(0, 1, 1, 'h01);
        step(0, 1, 1, 'h02);
        step(1, 1, 1, 'h99);

        for (int i = 0; i < 600; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op > 7) op = 1;
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                 op, int'($urandom_range(0, 255)));
        end

        step(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
